reg_bank_arbiter: RTL and testbench
===================================

REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of requesters sharing the register bank.
REQ-002 Parameter DW, default 32, register data width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester request pending.
REQ-006 req_write  input  NREQ  per-requester op type: 1 = write, 0 = read.
REQ-007 req_sel  input  3*NREQ  register index; requester i occupies bits [3i+2:3i].
REQ-008 req_data  input  DW*NREQ  write data; requester i occupies bits [DW*i+DW-1:DW*i].
REQ-009 req_ready  output  NREQ  one-hot accept strobe.
REQ-010 rsp_valid  output  NREQ  one-hot completion strobe.
REQ-011 rsp_data  output  DW  read data (read) or written data (write), qualified by rsp_valid.
REQ-012 bank_data  output  DW  to register bank data field.
REQ-013 bank_sel  output  3  to register bank select field.
REQ-014 bank_mode  output  1  to register bank mode field: 1 = write, 0 = read.
REQ-015 bank_q  input  DW  register bank read output.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, WR, RD.
REQ-017 In IDLE with any req_valid set, the arbiter SHALL grant exactly one requester, assert its req_ready combinationally that cycle, latch its write/sel/data/index, and move to WR or RD per req_write.
REQ-018 Arbitration SHALL be round-robin: the search starts at (last_grant+1) mod NREQ and takes the first set req_valid; last_grant updates only on a grant.
REQ-019 In IDLE with no req_valid set: no grant, state stays IDLE, last_grant unchanged.
REQ-020 req_ready SHALL be all-zero in WR and RD; requesters hold req_valid and operands stable until they see req_ready.
REQ-021 WR (one cycle): drive bank_mode=1, bank_sel and bank_data from the latched operands; next state IDLE.
REQ-022 RD (one cycle): drive bank_mode=0, bank_sel=latched sel; sample bank_q at end of cycle into rsp_data; next state IDLE.
REQ-023 In IDLE: bank_mode=0, bank_sel=0, bank_data=0; the block never leaves bank outputs undriven.
REQ-024 Timing: accept in cycle T; WR/RD in T+1; rsp_valid[granted] high for exactly one cycle in T+2.
REQ-025 In T+2, rsp_data SHALL equal bank_q sampled in RD (read) or the latched write data (write); rsp_data holds its value until the next completion.
REQ-026 A new grant in T+2 SHALL be permitted concurrently with the rsp_valid pulse; sustained throughput is one operation per 2 cycles.
REQ-027 A read accepted after a completed write to the same index SHALL return the written value; there is no hazard stall, because the write commits at the end of its WR cycle.
REQ-028 Maximum wait for a continuously-asserted request: NREQ-1 other grants.
REQ-029 Out-of-range or X inputs on non-granted requesters SHALL have no effect.

Reset
REQ-030 While reset=1 at posedge clk, the following SHALL hold at the next cycle: state=IDLE, last_grant=NREQ-1 (requester 0 has first priority), rsp_valid=0, rsp_data=0, latched operands=0.
REQ-031 While reset=1, req_ready=0 and bank_mode=0 combinationally, so no bank write occurs even if reset arrives during WR.
REQ-032 Reset arriving during WR or RD SHALL drop the in-flight operation without producing a rsp_valid pulse.

Verification
REQ-033 After reset: requester 1 writes sel=5, data=0xDEADBEEF -> req_ready[1] in T, bank_mode=1/bank_sel=5 in T+1, rsp_valid=3'b010 with rsp_data=0xDEADBEEF in T+2.
REQ-034 Requester 0 then reads sel=5 -> bank_mode=0/bank_sel=5 in RD, rsp_valid=3'b001 with rsp_data=0xDEADBEEF two cycles after accept.
REQ-035 All three requesters hold req_valid continuously after reset -> grant order 0,1,2,0,1,2, one grant every 2 cycles, no requester skipped.
REQ-036 Only requester 2 is active, with back-to-back requests -> granted every 2 cycles; last_grant stays 2; with 0 and 2 then both active, next grant goes to 0.
REQ-037 reset asserted during a WR cycle to sel=3 -> bank_mode=0 that cycle, no rsp_valid, state IDLE next cycle; a subsequent read of sel=3 returns the bank's pre-existing value.
REQ-038 Write sel=7 then read sel=7 with the read accepted in the same cycle as the write's rsp_valid -> the read returns the new value.

Source files
------------

// File: rtl/reg_bank_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_arbiter_if
// Description : Requester-side and register-bank-side signal bundle for the
//               shared register bank arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_bank_arbiter_if #(
    parameter int NREQ = 3,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_write;
    logic [3*NREQ-1:0]  req_sel;
    logic [DW*NREQ-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic [DW-1:0]      bank_data;
    logic [2:0]         bank_sel;
    logic               bank_mode;
    logic [DW-1:0]      bank_q;

    // Arbiter side
    modport slave (
        input  req_valid, req_write, req_sel, req_data, bank_q,
        output req_ready, rsp_valid, rsp_data, bank_data, bank_sel, bank_mode
    );

    // Requesters plus register bank side
    modport master (
        output req_valid, req_write, req_sel, req_data, bank_q,
        input  req_ready, rsp_valid, rsp_data, bank_data, bank_sel, bank_mode
    );
endinterface
`default_nettype wire

// File: rtl/reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_arbiter
// Description : Round-robin arbiter giving NREQ requesters one-at-a-time
//               access to a register bank. Accept in T, bank access in T+1,
//               one-cycle completion strobe in T+2.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32
) (
    input  wire logic         clk,
    input  wire logic         reset,
    reg_bank_arbiter_if.slave bus
);
    localparam int c_IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WR   = 2'd1;
    localparam logic [1:0] c_RD   = 2'd2;

    logic [1:0]      r_state;
    logic [c_IW-1:0] r_last;
    logic [c_IW-1:0] r_idx;
    logic [DW-1:0]   r_data;
    logic [NREQ-1:0] r_rsp_valid;
    logic [DW-1:0]   r_rsp_data;
    logic            r_bank_mode;
    logic [2:0]      r_bank_sel;
    logic [DW-1:0]   r_bank_data;

    logic            w_gnt_any;
    logic [c_IW-1:0] w_gnt_idx;
    logic [c_IW-1:0] w_probe;
    int              w_sum;
    logic [2:0]      w_sel_arr  [NREQ];
    logic [DW-1:0]   w_data_arr [NREQ];

    // Per-requester operand slices so the grant index can select them directly
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_sel_arr[gi]  = bus.req_sel[3*gi+2:3*gi];
        assign w_data_arr[gi] = bus.req_data[DW*gi+DW-1:DW*gi];
    end

    // Round-robin search starting one past the last granted requester
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_sum     = 0;
        w_probe   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_sum = int'(r_last) + k;
            if (w_sum >= NREQ) begin
                w_sum = w_sum - NREQ;
            end
            w_probe = c_IW'(w_sum);
            if (!w_gnt_any && bus.req_valid[w_probe]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_probe;
            end
        end
    end

    // Accept strobe only while idle and out of reset
    assign bus.req_ready = (r_state == c_IDLE && !reset && w_gnt_any)
                         ? (NREQ'(1) << w_gnt_idx) : '0;

    // Reset masks the write strobe so an in-flight write never reaches the bank
    assign bus.bank_mode = r_bank_mode & ~reset;
    assign bus.bank_sel  = r_bank_sel;
    assign bus.bank_data = r_bank_data;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;

    // Arbiter FSM with registered bank drive and completion outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_last      <= c_IW'(NREQ - 1);
            r_idx       <= '0;
            r_data      <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_bank_mode <= 1'b0;
            r_bank_sel  <= '0;
            r_bank_data <= '0;
        end else begin
            r_rsp_valid <= '0;
            r_bank_mode <= 1'b0;
            r_bank_sel  <= '0;
            r_bank_data <= '0;
            case (r_state)
                c_IDLE: begin
                    if (w_gnt_any) begin
                        r_idx      <= w_gnt_idx;
                        r_last     <= w_gnt_idx;
                        r_data     <= w_data_arr[w_gnt_idx];
                        r_bank_sel <= w_sel_arr[w_gnt_idx];
                        if (bus.req_write[w_gnt_idx]) begin
                            r_state     <= c_WR;
                            r_bank_mode <= 1'b1;
                            r_bank_data <= w_data_arr[w_gnt_idx];
                        end else begin
                            r_state <= c_RD;
                        end
                    end
                end
                c_WR: begin
                    r_rsp_valid[r_idx] <= 1'b1;
                    r_rsp_data         <= r_data;
                    r_state            <= c_IDLE;
                end
                c_RD: begin
                    r_rsp_valid[r_idx] <= 1'b1;
                    r_rsp_data         <= bus.bank_q;
                    r_state            <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bank_arbiter
// Description : Directed, table-driven bench for reg_bank_arbiter with a
//               behavioural 8-entry register bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank_arbiter;
    localparam int c_NREQ = 3;
    localparam int c_DW   = 32;

    typedef struct {
        logic        rst;
        logic [2:0]  v;
        logic [2:0]  w;
        logic [8:0]  sel;
        logic [95:0] data;
        logic [2:0]  e_rdy;
        logic [2:0]  e_rv;
        logic        e_mode;
        logic [2:0]  e_sel;
        logic [31:0] e_bdata;
        logic        chk_d;
        logic [31:0] e_d;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [31:0] model_regs [8];
    vec_t tbl [$];

    reg_bank_arbiter_if #(.NREQ(c_NREQ), .DW(c_DW)) bus ();

    reg_bank_arbiter #(.NREQ(c_NREQ), .DW(c_DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register bank: combinational read, write on clock edge
    assign bus.bank_q = model_regs[bus.bank_sel];
    always @(posedge clk) begin
        if (bus.bank_mode) model_regs[bus.bank_sel] <= bus.bank_data;
    end

    function automatic vec_t mk(logic rst, logic [2:0] v, logic [2:0] w,
                                logic [8:0] sel, logic [95:0] data,
                                logic [2:0] e_rdy, logic [2:0] e_rv,
                                logic e_mode, logic [2:0] e_sel,
                                logic [31:0] e_bdata, logic chk_d,
                                logic [31:0] e_d);
        vec_t t;
        t.rst = rst; t.v = v; t.w = w; t.sel = sel; t.data = data;
        t.e_rdy = e_rdy; t.e_rv = e_rv; t.e_mode = e_mode; t.e_sel = e_sel;
        t.e_bdata = e_bdata; t.chk_d = chk_d; t.e_d = e_d;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, compare mid-cycle, advance past the edge
    task automatic apply(vec_t t, string tag);
        reset         = t.rst;
        bus.req_valid = t.v;
        bus.req_write = t.w;
        bus.req_sel   = t.sel;
        bus.req_data  = t.data;
        @(negedge clk);
        chk({tag, " req_ready"}, 32'(bus.req_ready), 32'(t.e_rdy));
        chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(t.e_rv));
        chk({tag, " bank_mode"}, 32'(bus.bank_mode), 32'(t.e_mode));
        chk({tag, " bank_sel"},  32'(bus.bank_sel),  32'(t.e_sel));
        if (t.e_mode) chk({tag, " bank_data"}, bus.bank_data, t.e_bdata);
        if (t.chk_d)  chk({tag, " rsp_data"},  bus.rsp_data,  t.e_d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0]  s_rr;
        logic [95:0] d_wr;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 8; i++) model_regs[i] = 32'h1000_0000 + i;
        reset = 1'b1;
        bus.req_valid = '0; bus.req_write = '0; bus.req_sel = '0; bus.req_data = '0;

        s_rr = {3'd2, 3'd1, 3'd4};
        // write by requester 1, then read-back by requester 0
        tbl.push_back(mk(1, 3'b000, 3'b000, 9'd0, 96'd0, 3'b000, 3'b000, 0, 3'd0, 32'd0, 1, 32'd0));
        tbl.push_back(mk(0, 3'b010, 3'b010, {3'd0, 3'd5, 3'd0}, {32'd0, 32'hDEADBEEF, 32'd0},
                         3'b010, 3'b000, 0, 3'd0, 32'd0, 1, 32'd0));
        tbl.push_back(mk(0, 3'b000, 3'b000, 9'd0, 96'd0, 3'b000, 3'b000, 1, 3'd5, 32'hDEADBEEF, 0, 32'd0));
        tbl.push_back(mk(0, 3'b001, 3'b000, {3'd0, 3'd0, 3'd5}, 96'd0,
                         3'b001, 3'b010, 0, 3'd0, 32'd0, 1, 32'hDEADBEEF));
        tbl.push_back(mk(0, 3'b000, 3'b000, 9'd0, 96'd0, 3'b000, 3'b000, 0, 3'd5, 32'd0, 0, 32'd0));
        tbl.push_back(mk(0, 3'b000, 3'b000, 9'd0, 96'd0, 3'b000, 3'b001, 0, 3'd0, 32'd0, 1, 32'hDEADBEEF));
        // reset, then all three requesters hold valid: order 0,1,2,0,1,2
        tbl.push_back(mk(1, 3'b000, 3'b000, 9'd0, 96'd0, 3'b000, 3'b000, 0, 3'd0, 32'd0, 0, 32'd0));
        tbl.push_back(mk(0, 3'b111, 3'b000, s_rr, 96'd0, 3'b001, 3'b000, 0, 3'd0, 32'd0, 1, 32'd0));
        tbl.push_back(mk(0, 3'b111, 3'b000, s_rr, 96'd0, 3'b000, 3'b000, 0, 3'd4, 32'd0, 0, 32'd0));
        tbl.push_back(mk(0, 3'b111, 3'b000, s_rr, 96'd0, 3'b010, 3'b001, 0, 3'd0, 32'd0, 1, 32'h1000_0004));
        tbl.push_back(mk(0, 3'b111, 3'b000, s_rr, 96'd0, 3'b000, 3'b000, 0, 3'd1, 32'd0, 0, 32'd0));
        tbl.push_back(mk(0, 3'b111, 3'b000, s_rr, 96'd0, 3'b100, 3'b010, 0, 3'd0, 32'd0, 1, 32'h1000_0001));
        tbl.push_back(mk(0, 3'b111, 3'b000, s_rr, 96'd0, 3'b000, 3'b000, 0, 3'd2, 32'd0, 0, 32'd0));
        tbl.push_back(mk(0, 3'b111, 3'b000, s_rr, 96'd0, 3'b001, 3'b100, 0, 3'd0, 32'd0, 1, 32'h1000_0002));
        tbl.push_back(mk(0, 3'b111, 3'b000, s_rr, 96'd0, 3'b000, 3'b000, 0, 3'd4, 32'd0, 0, 32'd0));
        tbl.push_back(mk(0, 3'b111, 3'b000, s_rr, 96'd0, 3'b010, 3'b001, 0, 3'd0, 32'd0, 1, 32'h1000_0004));
        tbl.push_back(mk(0, 3'b111, 3'b000, s_rr, 96'd0, 3'b000, 3'b000, 0, 3'd1, 32'd0, 0, 32'd0));
        tbl.push_back(mk(0, 3'b111, 3'b000, s_rr, 96'd0, 3'b100, 3'b010, 0, 3'd0, 32'd0, 1, 32'h1000_0001));
        // only requester 2 active back-to-back, then 0 joins
        tbl.push_back(mk(0, 3'b100, 3'b000, s_rr, 96'd0, 3'b000, 3'b000, 0, 3'd2, 32'd0, 0, 32'd0));
        tbl.push_back(mk(0, 3'b100, 3'b000, s_rr, 96'd0, 3'b100, 3'b100, 0, 3'd0, 32'd0, 1, 32'h1000_0002));
        tbl.push_back(mk(0, 3'b100, 3'b000, s_rr, 96'd0, 3'b000, 3'b000, 0, 3'd2, 32'd0, 0, 32'd0));
        tbl.push_back(mk(0, 3'b100, 3'b000, s_rr, 96'd0, 3'b100, 3'b100, 0, 3'd0, 32'd0, 1, 32'h1000_0002));
        tbl.push_back(mk(0, 3'b100, 3'b000, s_rr, 96'd0, 3'b000, 3'b000, 0, 3'd2, 32'd0, 0, 32'd0));
        tbl.push_back(mk(0, 3'b101, 3'b000, s_rr, 96'd0, 3'b001, 3'b100, 0, 3'd0, 32'd0, 1, 32'h1000_0002));
        tbl.push_back(mk(0, 3'b101, 3'b000, s_rr, 96'd0, 3'b000, 3'b000, 0, 3'd4, 32'd0, 0, 32'd0));
        tbl.push_back(mk(0, 3'b101, 3'b000, s_rr, 96'd0, 3'b100, 3'b001, 0, 3'd0, 32'd0, 1, 32'h1000_0004));
        tbl.push_back(mk(0, 3'b000, 3'b000, s_rr, 96'd0, 3'b000, 3'b000, 0, 3'd2, 32'd0, 0, 32'd0));
        tbl.push_back(mk(0, 3'b000, 3'b000, s_rr, 96'd0, 3'b000, 3'b100, 0, 3'd0, 32'd0, 1, 32'h1000_0002));

        repeat (2) @(posedge clk);
        #1;
        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // write sel 7, read sel 7 accepted in the write's completion cycle;
        // non-granted requesters carry junk operands
        d_wr = {32'hBAD0_BAD0, 32'hCAFE_F00D, 32'hFFFF_FFFF};
        apply(mk(0, 3'b010, 3'b111, {3'd1, 3'd7, 3'd6}, d_wr,
                 3'b010, 3'b000, 0, 3'd0, 32'd0, 0, 32'd0), "raw_accept_wr");
        apply(mk(0, 3'b000, 3'b000, 9'd0, 96'd0,
                 3'b000, 3'b000, 1, 3'd7, 32'hCAFE_F00D, 0, 32'd0), "raw_wr");
        apply(mk(0, 3'b100, 3'b000, {3'd7, 3'd0, 3'd0}, 96'd0,
                 3'b100, 3'b010, 0, 3'd0, 32'd0, 1, 32'hCAFE_F00D), "raw_accept_rd");
        apply(mk(0, 3'b000, 3'b000, 9'd0, 96'd0,
                 3'b000, 3'b000, 0, 3'd7, 32'd0, 0, 32'd0), "raw_rd");
        apply(mk(0, 3'b000, 3'b000, 9'd0, 96'd0,
                 3'b000, 3'b100, 0, 3'd0, 32'd0, 1, 32'hCAFE_F00D), "raw_done");

        // reset lands on the WR cycle of a write to sel 3: write is dropped
        apply(mk(0, 3'b001, 3'b001, {3'd0, 3'd0, 3'd3}, {64'd0, 32'h1234_5678},
                 3'b001, 3'b000, 0, 3'd0, 32'd0, 0, 32'd0), "rstwr_accept");
        apply(mk(1, 3'b000, 3'b000, 9'd0, 96'd0,
                 3'b000, 3'b000, 0, 3'd3, 32'd0, 0, 32'd0), "rstwr_wr");
        apply(mk(0, 3'b000, 3'b000, 9'd0, 96'd0,
                 3'b000, 3'b000, 0, 3'd0, 32'd0, 1, 32'd0), "rstwr_after");
        apply(mk(0, 3'b001, 3'b000, {3'd0, 3'd0, 3'd3}, 96'd0,
                 3'b001, 3'b000, 0, 3'd0, 32'd0, 0, 32'd0), "rstwr_accept_rd");
        apply(mk(0, 3'b000, 3'b000, 9'd0, 96'd0,
                 3'b000, 3'b000, 0, 3'd3, 32'd0, 0, 32'd0), "rstwr_rd");
        apply(mk(0, 3'b000, 3'b000, 9'd0, 96'd0,
                 3'b000, 3'b001, 0, 3'd0, 32'd0, 1, 32'h1000_0003), "rstwr_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
